// File: rtl/reg_write_arbiter_pkg.sv
// Shared writeback types for the 8-bit core: register address/data widths and the
// write-request record used by the arbiter, register file and control unit.
package reg_write_arbiter_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int RF_ADDR_W  = 8;
  localparam int COUNT_W    = 3;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

  // The register file's INADDRESS is wider than the architectural register index.
  function automatic logic [RF_ADDR_W-1:0] rf_addr(input logic [REG_ADDR_W-1:0] addr);
    return {{(RF_ADDR_W-REG_ADDR_W){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback bus between the ALU/load paths and the register-file write port.
// Read-port forwarding signals exist only when REG_WR_FORWARD_EN is defined.
interface reg_write_arbiter_if;
  import reg_write_arbiter_pkg::*;

  logic                  ALU_VALID;
  logic [REG_ADDR_W-1:0] ALU_ADDR;
  logic [REG_DATA_W-1:0] ALU_DATA;
  logic                  ALU_READY;
  logic                  MEM_VALID;
  logic [REG_ADDR_W-1:0] MEM_ADDR;
  logic [REG_DATA_W-1:0] MEM_DATA;
  logic                  WRITE;
  logic [RF_ADDR_W-1:0]  WR_ADDR;
  logic [REG_DATA_W-1:0] WR_DATA;
  logic                  BUSY;
  logic [COUNT_W-1:0]    COUNT;
`ifdef REG_WR_FORWARD_EN
  logic [REG_ADDR_W-1:0] RD1_ADDR;
  logic [REG_ADDR_W-1:0] RD2_ADDR;
  logic                  FWD1_HIT;
  logic [REG_DATA_W-1:0] FWD1_DATA;
  logic                  FWD2_HIT;
  logic [REG_DATA_W-1:0] FWD2_DATA;

  modport master (
    output ALU_VALID, ALU_ADDR, ALU_DATA, MEM_VALID, MEM_ADDR, MEM_DATA, RD1_ADDR, RD2_ADDR,
    input  ALU_READY, WRITE, WR_ADDR, WR_DATA, BUSY, COUNT,
           FWD1_HIT, FWD1_DATA, FWD2_HIT, FWD2_DATA
  );

  modport slave (
    input  ALU_VALID, ALU_ADDR, ALU_DATA, MEM_VALID, MEM_ADDR, MEM_DATA, RD1_ADDR, RD2_ADDR,
    output ALU_READY, WRITE, WR_ADDR, WR_DATA, BUSY, COUNT,
           FWD1_HIT, FWD1_DATA, FWD2_HIT, FWD2_DATA
  );
`else
  modport master (
    output ALU_VALID, ALU_ADDR, ALU_DATA, MEM_VALID, MEM_ADDR, MEM_DATA,
    input  ALU_READY, WRITE, WR_ADDR, WR_DATA, BUSY, COUNT
  );

  modport slave (
    input  ALU_VALID, ALU_ADDR, ALU_DATA, MEM_VALID, MEM_ADDR, MEM_DATA,
    output ALU_READY, WRITE, WR_ADDR, WR_DATA, BUSY, COUNT
  );
`endif

endinterface

// File: rtl/reg_write_arbiter_wr_defer_fifo.sv
// In-order buffer of deferred ALU writes. Entries stay packed from index 0 (head),
// so the tail pointer is the occupancy; invalidated entries are squeezed out.
module wr_defer_fifo
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [REG_DATA_W-1:0] push_data,
  input  logic                  pop,
  input  logic [REG_ADDR_W-1:0] lookup_addr,
  output logic [DEPTH-1:0]      lookup_hit,
  input  logic                  overwrite,
  input  logic [REG_DATA_W-1:0] overwrite_data,
  input  logic                  invalidate,
  input  logic [REG_ADDR_W-1:0] invalidate_addr,
  output wr_req_t               head,
  output logic [COUNT_W-1:0]    count,
  output logic                  full
`ifdef REG_WR_FORWARD_EN
  ,
  output wr_req_t               entries [DEPTH]
`endif
);

  wr_req_t            entry_q   [DEPTH];
  wr_req_t            entry_mod [DEPTH];
  wr_req_t            entry_d   [DEPTH];
  logic [DEPTH-1:0]   keep;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic [COUNT_W-1:0] pos;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      lookup_hit[i] = entry_q[i].valid && (entry_q[i].addr == lookup_addr);
      entry_mod[i]  = entry_q[i];
      if (overwrite && lookup_hit[i]) begin
        entry_mod[i].data = overwrite_data;
      end
      keep[i] = entry_q[i].valid && !(pop && (i == 0)) &&
                !(invalidate && (entry_q[i].addr == invalidate_addr));
    end
  end

  // Removal happens before the push, so a new entry survives a same-address invalidate.
  always_comb begin
    pos = '0;
    for (int j = 0; j < DEPTH; j++) begin
      entry_d[j] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (pos == COUNT_W'(j)) begin
            entry_d[j] = entry_mod[i];
          end
        end
        pos = pos + COUNT_W'(1);
      end
    end
    if (push) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (pos == COUNT_W'(j)) begin
          entry_d[j] = '{valid: 1'b1, addr: push_addr, data: push_data};
        end
      end
    end
    count_d = pos + COUNT_W'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      count_q <= count_d;
    end
  end

  assign head  = entry_q[0];
  assign count = count_q;
  assign full  = (count_q == COUNT_W'(DEPTH));

`ifdef REG_WR_FORWARD_EN
  assign entries = entry_q;
`endif

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the single register-file write port between load and ALU writeback.
// Optional read-port forwarding is enabled with REG_WR_FORWARD_EN.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic               CLK,
  input logic               RESET,
  reg_write_arbiter_if.slave bus
);

  wr_req_t               head;
  logic [DEPTH-1:0]      lookup_hit;
  logic [COUNT_W-1:0]    count;
  logic                  full;
  logic                  alu_accept;
  logic                  same_as_mem;
  logic                  coalesce;
  logic                  head_issue;
  logic                  alu_direct;
  logic                  push;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_addr;
  logic [REG_DATA_W-1:0] issue_data;
  logic                  write_q;
  logic [RF_ADDR_W-1:0]  wr_addr_q;
  logic [REG_DATA_W-1:0] wr_data_q;
`ifdef REG_WR_FORWARD_EN
  wr_req_t               entries [DEPTH];
`endif

  // A same-address MEM write supersedes the old entry, so that ALU write is pushed fresh.
  assign alu_accept  = bus.ALU_VALID && !full;
  assign same_as_mem = bus.MEM_VALID && (bus.MEM_ADDR == bus.ALU_ADDR);
  assign coalesce    = alu_accept && (|lookup_hit) && !same_as_mem;
  assign head_issue  = !bus.MEM_VALID && head.valid;
  assign alu_direct  = alu_accept && !bus.MEM_VALID && !head.valid;
  assign push        = alu_accept && !alu_direct && !coalesce;

  wr_defer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk             (CLK),
    .rst_n           (RESET),
    .push            (push),
    .push_addr       (bus.ALU_ADDR),
    .push_data       (bus.ALU_DATA),
    .pop             (head_issue),
    .lookup_addr     (bus.ALU_ADDR),
    .lookup_hit      (lookup_hit),
    .overwrite       (coalesce),
    .overwrite_data  (bus.ALU_DATA),
    .invalidate      (bus.MEM_VALID),
    .invalidate_addr (bus.MEM_ADDR),
    .head            (head),
    .count           (count),
    .full            (full)
`ifdef REG_WR_FORWARD_EN
    ,
    .entries         (entries)
`endif
  );

  // A head that is coalesced while issuing goes out with the newer ALU data.
  always_comb begin
    issue_valid = 1'b0;
    issue_addr  = '0;
    issue_data  = '0;
    if (bus.MEM_VALID) begin
      issue_valid = 1'b1;
      issue_addr  = bus.MEM_ADDR;
      issue_data  = bus.MEM_DATA;
    end else if (head_issue) begin
      issue_valid = 1'b1;
      issue_addr  = head.addr;
      issue_data  = (coalesce && lookup_hit[0]) ? bus.ALU_DATA : head.data;
    end else if (alu_direct) begin
      issue_valid = 1'b1;
      issue_addr  = bus.ALU_ADDR;
      issue_data  = bus.ALU_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      write_q <= issue_valid;
      if (issue_valid) begin
        wr_addr_q <= rf_addr(issue_addr);
        wr_data_q <= issue_data;
      end
    end
  end

  assign bus.ALU_READY = !full;
  assign bus.WRITE     = write_q;
  assign bus.WR_ADDR   = wr_addr_q;
  assign bus.WR_DATA   = wr_data_q;
  assign bus.BUSY      = head.valid || write_q;
  assign bus.COUNT     = count;

`ifdef REG_WR_FORWARD_EN
  // Later matches override earlier ones: younger buffer entries, then the output stage.
  always_comb begin
    bus.FWD1_HIT  = 1'b0;
    bus.FWD1_DATA = '0;
    bus.FWD2_HIT  = 1'b0;
    bus.FWD2_DATA = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (entries[i].addr == bus.RD1_ADDR)) begin
        bus.FWD1_HIT  = 1'b1;
        bus.FWD1_DATA = entries[i].data;
      end
      if (entries[i].valid && (entries[i].addr == bus.RD2_ADDR)) begin
        bus.FWD2_HIT  = 1'b1;
        bus.FWD2_DATA = entries[i].data;
      end
    end
    if (write_q && (wr_addr_q == rf_addr(bus.RD1_ADDR))) begin
      bus.FWD1_HIT  = 1'b1;
      bus.FWD1_DATA = wr_data_q;
    end
    if (write_q && (wr_addr_q == rf_addr(bus.RD2_ADDR))) begin
      bus.FWD2_HIT  = 1'b1;
      bus.FWD2_DATA = wr_data_q;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (DEPTH = 2): expected writes are queued as
// stimulus is issued and a negedge monitor checks every WRITE the DUT presents.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [REG_ADDR_W+REG_DATA_W-1:0] exp_q [$];

  reg_write_arbiter_if bus ();

  reg_write_arbiter #(.DEPTH(2)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expect_write(input logic [REG_ADDR_W-1:0] addr, input logic [REG_DATA_W-1:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic apply_stimulus(input logic mem_v, input logic [2:0] mem_a, input logic [7:0] mem_d,
                                input logic alu_v, input logic [2:0] alu_a, input logic [7:0] alu_d);
    bus.MEM_VALID = mem_v;
    bus.MEM_ADDR  = mem_a;
    bus.MEM_DATA  = mem_d;
    bus.ALU_VALID = alu_v;
    bus.ALU_ADDR  = alu_a;
    bus.ALU_DATA  = alu_d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      idle(1);
    end
    idle(2);
    check_output({name, "_pending"}, 8'(exp_q.size()), 8'd0);
    check_output({name, "_count"}, 8'(bus.COUNT), 8'd0);
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.WRITE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.WR_ADDR, bus.WR_DATA);
      end else begin
        logic [REG_ADDR_W+REG_DATA_W-1:0] exp_w;
        exp_w = exp_q.pop_front();
        check_output("write_addr", bus.WR_ADDR, rf_addr(exp_w[REG_ADDR_W+REG_DATA_W-1:REG_DATA_W]));
        check_output("write_data", bus.WR_DATA, exp_w[REG_DATA_W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
`ifdef REG_WR_FORWARD_EN
    bus.RD1_ADDR = '0;
    bus.RD2_ADDR = '0;
`endif

    // Reset held with both requests valid.
    rst_n         = 1'b0;
    bus.MEM_VALID = 1'b1;
    bus.MEM_ADDR  = 3'd1;
    bus.MEM_DATA  = 8'h77;
    bus.ALU_VALID = 1'b1;
    bus.ALU_ADDR  = 3'd2;
    bus.ALU_DATA  = 8'h88;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_write", 8'(bus.WRITE), 8'd0);
    check_output("reset_count", 8'(bus.COUNT), 8'd0);
    check_output("reset_ready", 8'(bus.ALU_READY), 8'd1);
    check_output("reset_busy", 8'(bus.BUSY), 8'd0);
    check_output("reset_wr_addr", bus.WR_ADDR, 8'h00);
    bus.MEM_VALID = 1'b0;
    bus.ALU_VALID = 1'b0;
    rst_n         = 1'b1;

    $display("[TB] first ALU write after reset");
    expect_write(3'd3, 8'h5A);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h5A);
    check_output("first_busy", 8'(bus.BUSY), 8'd1);
    wait_drain("first");

    $display("[TB] MEM/ALU collision");
    expect_write(3'd1, 8'h11);
    expect_write(3'd2, 8'h22);
    apply_stimulus(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    check_output("collide_count_n1", 8'(bus.COUNT), 8'd1);
    idle(1);
    check_output("collide_count_n2", 8'(bus.COUNT), 8'd0);
    wait_drain("collide");

    $display("[TB] full buffer with held ALU request");
    expect_write(3'd0, 8'hA0);
    expect_write(3'd1, 8'hA1);
    expect_write(3'd2, 8'hA2);
    expect_write(3'd3, 8'hA3);
    expect_write(3'd4, 8'h44);
    expect_write(3'd5, 8'h55);
    expect_write(3'd1, 8'h66);
    apply_stimulus(1'b1, 3'd0, 8'hA0, 1'b1, 3'd4, 8'h44);
    check_output("full_count_1", 8'(bus.COUNT), 8'd1);
    apply_stimulus(1'b1, 3'd1, 8'hA1, 1'b1, 3'd5, 8'h55);
    check_output("full_ready_low", 8'(bus.ALU_READY), 8'd0);
    check_output("full_count_2", 8'(bus.COUNT), 8'd2);
    apply_stimulus(1'b1, 3'd2, 8'hA2, 1'b1, 3'd1, 8'h66);
    apply_stimulus(1'b1, 3'd3, 8'hA3, 1'b1, 3'd1, 8'h66);
    check_output("full_ready_held", 8'(bus.ALU_READY), 8'd0);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h66);
    check_output("drain_ready_up", 8'(bus.ALU_READY), 8'd1);
    check_output("drain_count", 8'(bus.COUNT), 8'd1);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h66);
    check_output("pop_push_count", 8'(bus.COUNT), 8'd1);
    wait_drain("full");

    $display("[TB] coalesce into buffered entry");
    expect_write(3'd0, 8'h10);
    expect_write(3'd1, 8'h20);
    expect_write(3'd6, 8'h02);
    apply_stimulus(1'b1, 3'd0, 8'h10, 1'b1, 3'd6, 8'h01);
    apply_stimulus(1'b1, 3'd1, 8'h20, 1'b1, 3'd6, 8'h02);
    check_output("coalesce_count", 8'(bus.COUNT), 8'd1);
    wait_drain("coalesce");

    $display("[TB] MEM supersedes buffered entry");
    expect_write(3'd0, 8'h30);
    expect_write(3'd7, 8'hBB);
    apply_stimulus(1'b1, 3'd0, 8'h30, 1'b1, 3'd7, 8'hAA);
    apply_stimulus(1'b1, 3'd7, 8'hBB, 1'b0, 3'd0, 8'h00);
    check_output("supersede_count", 8'(bus.COUNT), 8'd0);
    wait_drain("supersede");

    $display("[TB] push and supersede on the same address");
    expect_write(3'd0, 8'h40);
    expect_write(3'd2, 8'h02);
    expect_write(3'd2, 8'h03);
    apply_stimulus(1'b1, 3'd0, 8'h40, 1'b1, 3'd2, 8'h01);
    apply_stimulus(1'b1, 3'd2, 8'h02, 1'b1, 3'd2, 8'h03);
    check_output("push_supersede_count", 8'(bus.COUNT), 8'd1);
    wait_drain("push_supersede");

    $display("[TB] reset with a full buffer");
    expect_write(3'd0, 8'h50);
    expect_write(3'd1, 8'h51);
    apply_stimulus(1'b1, 3'd0, 8'h50, 1'b1, 3'd3, 8'h61);
    apply_stimulus(1'b1, 3'd1, 8'h51, 1'b1, 3'd4, 8'h62);
    check_output("midreset_pre_count", 8'(bus.COUNT), 8'd2);
    bus.MEM_VALID = 1'b0;
    bus.ALU_VALID = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midreset_write", 8'(bus.WRITE), 8'd0);
    check_output("midreset_count", 8'(bus.COUNT), 8'd0);
    check_output("midreset_ready", 8'(bus.ALU_READY), 8'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    wait_drain("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the single register-file write port between the ALU writeback path and the memory-load writeback path of the 8-bit single-cycle processor. Each cycle it picks at most one write and drives the register file's WRITE/INADDRESS/IN from registered outputs. ALU writes that lose arbitration are held in a small in-order buffer instead of stalling the core.

## Interface
Parameters:
- DEPTH, 2, ALU deferral buffer entries (legal 1..4)

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- ALU_VALID  in  1  ALU writeback request this cycle
- ALU_ADDR  in  3  ALU destination register
- ALU_DATA  in  8  ALU result
- ALU_READY  out  1  ALU request accepted this cycle; equals buffer not full
- MEM_VALID  in  1  load writeback request; always accepted
- MEM_ADDR  in  3  load destination register
- MEM_DATA  in  8  load data
- WRITE  out  1  register-file write enable (registered)
- WR_ADDR  out  8  register-file INADDRESS; bits [7:3] always 0
- WR_DATA  out  8  register-file IN
- BUSY  out  1  buffer non-empty or WRITE high
- COUNT  out  3  current buffer occupancy

## Operation
- Accepted ALU request: ALU_VALID && ALU_READY. A MEM request is always accepted.
- Issue priority each cycle: MEM, then buffer head, then accepted ALU direct. At most one write issues per cycle.
- An accepted ALU request that does not issue this cycle is pushed to the buffer tail.
- Buffer order is strict FIFO. The head pops only when it issues.
- Coalescing: if an accepted ALU address equals a valid buffer entry's address, that entry's data is overwritten in place. No new entry is allocated, and order is unchanged.
- Supersede: if a MEM write issues with an address equal to a buffered entry's address, that entry is invalidated and removed without issuing. The pipeline guarantees the MEM write is architecturally newer.
- Push and supersede in the same cycle with the same address: the pushed ALU entry is kept and the older entry is dropped.
- Full buffer, ALU_VALID high: ALU_READY = 0 and the request is not accepted. The ALU holds ALU_VALID/ADDR/DATA stable until accepted.
- Full buffer, MEM idle: the head drains, and ALU_READY rises the next cycle.
- Simultaneous pop and push: occupancy is unchanged.
- COUNT wraps never: it saturates at DEPTH by construction.
- DEPTH = 1: same rules; ALU_READY drops whenever one entry is held.

## Timing
- Latency: request accepted in cycle N gives WRITE/WR_ADDR/WR_DATA valid in cycle N+1, if it issued in cycle N.
- The register file captures the write on the following rising edge.
- Worst-case deferral for an ALU write: DEPTH + number of consecutive MEM cycles.
- ALU_READY is combinational from occupancy only. It does not depend on ALU_VALID or MEM_VALID.
- Reset values (asynchronous, RESET low): WRITE = 0, WR_ADDR = 0, WR_DATA = 0, COUNT = 0, BUSY = 0, ALU_READY = 1. All buffer entries are invalid.
- Reset mid-operation discards all buffered writes and any write pending on the outputs; WRITE falls immediately.
- First acceptance is allowed on the first rising edge after RESET deasserts.

## Configuration
- REG_WR_FORWARD_EN defined: adds inputs RD1_ADDR[2:0] and RD2_ADDR[2:0], and outputs FWD1_HIT, FWD1_DATA[7:0], FWD2_HIT, FWD2_DATA[7:0].
- Forwarding is combinational: it compares against the output stage and all valid buffer entries.
- Forwarding precedence when several match: output-stage write first, then youngest buffer entry.
- When no entry matches, HIT = 0 and DATA = 0.
- REG_WR_FORWARD_EN undefined: these ports and the compare logic are absent. All other behaviour is identical.

## Structure
- Shared package: REG_ADDR_W = 3, REG_DATA_W = 8, and typedef wr_req_t (valid, addr, data). The register file and the control unit use it as well.
- One sub-module: wr_defer_fifo. It holds the DEPTH-entry buffer with head/tail pointers, occupancy, per-entry valid, address-match vectors, and in-place overwrite and invalidate.
- Arbitration, output registers and forwarding sit in the top module.

## Test plan
- Reset: hold RESET low with both requests valid -> WRITE = 0, COUNT = 0, ALU_READY = 1. Release, then ALU (r3, 0x5A) -> next cycle WRITE = 1, WR_ADDR = 0x03, WR_DATA = 0x5A.
- Collision: MEM (r1, 0x11) and ALU (r2, 0x22) in the same cycle -> cycle N+1 writes r1 = 0x11 with COUNT = 1; cycle N+2 writes r2 = 0x22 with COUNT = 0.
- Full buffer: DEPTH = 2, hold MEM valid 4 cycles (r0..r3) with ALU (r4, 0x44) then (r5, 0x55) -> ALU_READY = 0 after two pushes. After MEM stops, the writes drain in order r4, r5.
- Coalesce: buffer holds r6 = 0x01, then ALU (r6, 0x02) accepted during MEM traffic -> COUNT stays 1 and exactly one write r6 = 0x02 issues.
- Supersede: buffer holds r7 = 0xAA, then MEM (r7, 0xBB) issues -> entry dropped, and the only write to r7 is 0xBB.
- Mid-operation reset: pulse RESET low with COUNT = 2 -> WRITE falls immediately and COUNT = 0. No buffered write appears after release.
